// File: rtl/check_pattern_pkg.sv
// Shared constants and types for the check_pattern serial pattern detector.
package check_pattern_pkg;

  localparam logic MODE_NONOVERLAP = 1'b0;
  localparam logic MODE_OVERLAP    = 1'b1;

  localparam int PAT_W_MAX = 32;
  localparam int CNT_W_MAX = 16;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_t;

endpackage

// File: rtl/check_pattern_window.sv
// Sliding window of the last PAT_W valid bits plus a saturating fill count.
// Exposes the post-update values so the top can compare in the same cycle.
module pat_window
  import check_pattern_pkg::*;
#(
  parameter int PAT_W  = 4,
  parameter int FILL_W = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x,
  input  logic              x_valid,
  input  logic              flush,
  output logic [PAT_W-1:0]  win_next,
  output logic [FILL_W-1:0] fill_next,
  output logic              armed
);

  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  win;
  logic [FILL_W-1:0] fill;

  // A one-bit window has no older bits to keep, so the shift degenerates.
  if (PAT_W == 1) begin : g_w1
    assign win_next = x_valid ? x : win;
  end else begin : g_wn
    assign win_next = x_valid ? {win[PAT_W-2:0], x} : win;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fill_next = fill;
    if (x_valid && fill != FULL) fill_next = fill + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      win  <= '0;
      fill <= '0;
    end else if (x_valid) begin
      win  <= win_next;
      fill <= flush ? '0 : fill_next;
    end
  end

  assign armed = (fill == FULL);

endmodule

// File: rtl/check_pattern.sv
// Parametrised serial pattern detector: compare, FSM policy, z pulse, match counter.
// Optional match counter built only when CHECK_PATTERN_CNT_EN is defined.
module check_pattern
  import check_pattern_pkg::*;
#(
  parameter int               PAT_W = 4,
  parameter logic [PAT_W-1:0] PAT   = 4'b1111,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  if (PAT_W < 1 || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("check_pattern: PAT_W out of range 1..%0d", PAT_W_MAX);
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("check_pattern: CNT_W out of range 1..%0d", CNT_W_MAX);
  end

  logic [PAT_W-1:0]  win_next;
  logic [FILL_W-1:0] fill_next;
  logic              armed;
  logic              match;
  logic              flush;
  state_t            state;

  assign match = x_valid && (fill_next == FULL) && (win_next == PAT);
  assign flush = match && (overlap == MODE_NONOVERLAP);

  pat_window #(.PAT_W(PAT_W), .FILL_W(FILL_W)) u_window (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_valid   (x_valid),
    .flush     (flush),
    .win_next  (win_next),
    .fill_next (fill_next),
    .armed     (armed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILLING;
      z     <= 1'b0;
    end else begin
      z <= match;
      if (x_valid) begin
        if (flush)                  state <= FILLING;
        else if (fill_next == FULL) state <= ARMED;
        else                        state <= FILLING;
      end
    end
  end

  // The window's fill count and the FSM must always agree on being armed.
  a_state_armed: assert property (@(posedge clk) disable iff (rst) (state == ARMED) == armed);

`ifdef CHECK_PATTERN_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over a coincident match; the match still pulses z.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)                  match_cnt <= '0;
    else if (match && match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_check_pattern.sv
// Directed, table-driven bench for check_pattern across three parameterisations.
module tb_check_pattern;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x = 1'b0;
  logic x_valid = 1'b0;
  logic overlap = 1'b1;
  logic clr_cnt = 1'b0;

  logic       z_def, z_p3, z_c2;
  logic [7:0] cnt_def, cnt_p3;
  logic [1:0] cnt_c2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  check_pattern #(.PAT_W(4), .PAT(4'b1111), .CNT_W(8)) u_def (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z_def), .match_cnt(cnt_def));

  check_pattern #(.PAT_W(3), .PAT(3'b101), .CNT_W(8)) u_p3 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z_p3), .match_cnt(cnt_p3));

  check_pattern #(.PAT_W(4), .PAT(4'b1111), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z_c2), .match_cnt(cnt_c2));

  function automatic int cnt_exp(input int v);
`ifdef CHECK_PATTERN_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic xb, input logic v,
                      input logic ov, input logic clr);
    rst = r; x = xb; x_valid = v; overlap = ov; clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst;
    logic x;
    logic v;
    logic ov;
    logic clr;
    logic exp_z;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[24];

  logic [23:0] word;
  int          pulses;

  initial begin
    vecs = '{
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0},            // reset
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0},            // overlap: 0111111 0
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, cnt_exp(1)},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, cnt_exp(2)},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cnt_exp(2)},  // invalid gap
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, cnt_exp(3)},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, cnt_exp(3)},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0},            // reset
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0},            // non-overlap
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, cnt_exp(1)},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cnt_exp(1)},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cnt_exp(1)},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cnt_exp(1)},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cnt_exp(1)},   // window 1101
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cnt_exp(1)},   // window 1011
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cnt_exp(1)},   // window 0111
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, cnt_exp(2)},   // window 1111
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0}             // refilling, clear
    };

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].rst, vecs[i].x, vecs[i].v, vecs[i].ov, vecs[i].clr);
      check($sformatf("vec%0d_z", i), int'(z_def), int'(vecs[i].exp_z));
      check($sformatf("vec%0d_cnt", i), int'(cnt_def), vecs[i].exp_cnt);
    end

    // 24-bit word, overlap on: matches complete at bits 10 and 21.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    word   = 24'b1100_0011_1101_0110_0111_1011;
    pulses = 0;
    for (int b = 1; b <= 24; b++) begin
      step(1'b0, word[24-b], 1'b1, 1'b1, 1'b0);
      pulses += int'(z_def);
      check($sformatf("word_bit%0d_z", b), int'(z_def), int'(b == 10 || b == 21));
    end
    check("word_pulses", pulses, 2);
    check("word_cnt", int'(cnt_def), cnt_exp(2));

    // 101 pattern with two invalid cycles between bits.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) begin
      step(1'b0, (b != 1), 1'b1, 1'b1, 1'b0);
      check($sformatf("p3_bit%0d_z", b), int'(z_p3), int'(b == 2));
      if (b < 2) begin
        for (int g = 0; g < 2; g++) begin
          step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
          check($sformatf("p3_gap%0d_%0d_z", b, g), int'(z_p3), 0);
        end
      end
    end

    // Two-bit counter: saturates at 3, clear on the 5th match edge.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      check($sformatf("c2_fill%0d_z", b), int'(z_c2), 0);
    end
    pulses = 0;
    for (int m = 1; m <= 5; m++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, (m == 5));
      pulses += int'(z_c2);
      check($sformatf("c2_match%0d_cnt", m), int'(cnt_c2),
            cnt_exp(m == 5 ? 0 : (m > 3 ? 3 : m)));
    end
    check("c2_pulses", pulses, 5);

    // Reset mid-stream after three ones; the bit under reset is dropped.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_mid_z", int'(z_def), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_first_one_z", int'(z_def), 0);
    pulses = 0;
    for (int b = 0; b < 4; b++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      pulses += int'(z_def);
      check($sformatf("rst_more%0d_z", b), int'(z_def), int'(b == 2));
    end
    check("rst_pulses", pulses, 1);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_z", int'(z_def), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/check_pattern.md
# check_pattern

Parametrised serial pattern detector for the serial front end, generalising the fixed four-ones detector. It samples one bit per qualified clock, compares a sliding window of the last `PAT_W` bits against a parameter pattern, and emits a one-cycle `z` pulse per match. It supports run-time overlapping or non-overlapping matching and keeps an optional saturating match counter. It sits directly on the serial input path, in front of the framing logic.

## Interface
- `PAT_W`, 4: pattern length in bits; legal range 1..32.
- `PAT`, 4'b1111: pattern value, `PAT_W` bits. The MSB is the oldest bit received.
- `CNT_W`, 8: match counter width; legal range 1..16.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `x`  in  1  serial data bit.
- `x_valid`  in  1  qualifies `x`. When low, the cycle is ignored and all state holds.
- `overlap`  in  1  1 = overlapping matches, 0 = non-overlapping. Sampled with each valid bit.
- `clr_cnt`  in  1  synchronous clear of `match_cnt`.
- `z`  out  1  registered match pulse.
- `match_cnt`  out  `CNT_W`  saturating count of matches.

## Operation
- Internal state:
  - `win`: `PAT_W`-bit shift register. On a valid bit, `win <= {win[PAT_W-2:0], x}`; for `PAT_W`=1, `win <= x`.
  - `fill`: count of valid bits in the current window; width `$clog2(PAT_W+1)`, saturates at `PAT_W`.
- Match condition, evaluated on the post-update values: `x_valid` && `fill_next`==`PAT_W` && `win_next`==`PAT`.
- FSM states, derived from `fill`:
  - FILLING: `fill` < `PAT_W`; no match is possible.
  - ARMED: `fill` == `PAT_W`.
- Overlapping mode (`overlap`=1): after a match, `fill` stays at `PAT_W`. The next valid bit may produce another match.
- Non-overlapping mode (`overlap`=0): a match forces `fill` to 0 and the FSM back to FILLING. `win` still shifts. The next match needs `PAT_W` fresh bits.
- A `PAT_W`-1 bit tail shorter than the pattern never matches.
- `match_cnt`:
  - Increments by 1 per match and saturates at 2^`CNT_W`-1; it never wraps.
  - `clr_cnt` has priority over a simultaneous match: the count goes to 0 and that match is not counted.
  - `z` still pulses for a match that coincides with `clr_cnt`.
- A change of `overlap` takes effect at the next valid bit. It does not reset `fill` or `win`.

## Timing
- Values after reset:
  - `z`=0, `match_cnt`=0.
  - `win`=0, `fill`=0, FSM in FILLING.
- `rst` mid-stream discards any partial window. A bit presented in the same cycle as `rst` is dropped.
- Latency: `z` rises on the same rising edge that samples the completing bit, so it is visible in the following cycle.
- `z` is high for exactly one cycle per match.
- `match_cnt` updates on the same edge as `z`.
- Back-to-back valid bits in overlapping mode can hold `z` high on consecutive cycles, one pulse per match.
- Cycles with `x_valid`=0 between bits are transparent to the match. `z` is low in any cycle whose edge had `x_valid`=0.

## Configuration
- Macro: `CHECK_PATTERN_CNT_EN`.
- Defined: the `match_cnt` register and `clr_cnt` logic are built as described above.
- Undefined:
  - `match_cnt` is tied to 0 and `clr_cnt` is ignored.
  - `z` behaviour is identical to the defined case.
  - No counter flops are synthesised.

## Structure
- Package `check_pattern_pkg`:
  - mode constants `MODE_NONOVERLAP`=1'b0 and `MODE_OVERLAP`=1'b1;
  - FSM state enum `FILLING`/`ARMED`;
  - parameter-range limits `PAT_W_MAX`=32 and `CNT_W_MAX`=16.
- Sub-module `pat_window`: holds `win` and `fill`. Its inputs are `x`, `x_valid` and a flush request; its outputs are `win_next`, `fill_next` and `armed`.
- The top level holds the compare, the FSM policy, `z` and the counter.
- Elaboration-time checks reject out-of-range `PAT_W` and `CNT_W`.

## Test plan
- Defaults, `overlap`=1, continuous valid stream of the 24-bit word 1100_0011_1101_0110_0111_1011, MSB first → exactly 2 `z` pulses, at bits 10 and 21 (1-indexed); `match_cnt`=2.
- Defaults, stream 0111111 0 → `overlap`=1 gives pulses at bits 5, 6 and 7 and `match_cnt`=3; `overlap`=0 gives a pulse only at bit 5 and `match_cnt`=1.
- `PAT_W`=3, `PAT`=3'b101, stream 1,0,1 with `x_valid` low for 2 cycles between each bit → one `z` pulse, on the edge sampling the last 1.
- `CNT_W`=2, 5 matches with `clr_cnt` asserted on the 5th match edge → count sequence 1,2,3,3 (saturated), then 0 after the clearing edge; `z` pulses 5 times.
- `rst` asserted after 3 ones of a 1111 pattern, then 1 more one → no `z`; after 4 further ones → `z` pulses once.
- Build without `CHECK_PATTERN_CNT_EN` → `match_cnt` stays 0 throughout scenario 1; the `z` trace is identical to the counter-enabled build.
